// File: rtl/prog_loader_pkg.sv
// Shared constants and state encodings for the program loader.
package prog_loader_pkg;

    // Number of 16-bit program words held by the loader.
    localparam int MEM_DEPTH = 16;

    // Word returned for any location that holds no loaded instruction.
    localparam logic [15:0] NOP_WORD = 16'h0000;

    // Loader FSM states; the encodings are visible on the state port.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        READY = 2'b10,
        RUN   = 2'b11
    } state_t;

endpackage

// File: rtl/prog_loader_word.sv
// One program word: 16-bit register with synchronous clear and write enable.
module prog_word (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [15:0] d,
    output logic [15:0] q
);

    import prog_loader_pkg::*;

    // Reset clears the word to a NOP; otherwise capture d when enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= NOP_WORD;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Program loader: accepts a program over a valid/ready stream, stores it,
// then releases the processor and serves instruction fetches from it.
module prog_loader #(
    parameter int MEM_DEPTH = prog_loader_pkg::MEM_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    input  logic [15:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] addr,
    output logic [15:0] ins,
    output logic        cpu_reset,
    output logic [4:0]  wcount,
    output logic [1:0]  state
);

    import prog_loader_pkg::*;

    localparam int          AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [4:0]  DEPTH_W = 5'(MEM_DEPTH);

    state_t                      cur_state;
    state_t                      next_state;
    logic [4:0]                  wcount_q;
    logic [4:0]                  next_wcount;
    logic                        cpu_reset_q;
    logic                        transfer;
    logic [MEM_DEPTH-1:0]        word_we;
    logic [MEM_DEPTH-1:0][15:0]  words;

    // The loader only accepts words while a program is being collected.
    assign ld_ready  = (cur_state == IDLE) || (cur_state == LOAD);
    assign transfer  = ld_valid && ld_ready;
    assign cpu_reset = cpu_reset_q;
    assign wcount    = wcount_q;
    assign state     = cur_state;

    // Each accepted word lands at the slot indexed by the running word count.
    genvar i;
    generate
        for (i = 0; i < MEM_DEPTH; i++) begin : g_word
            assign word_we[i] = transfer && (wcount_q == 5'(i));

            prog_word u_word (
                .clk   (clk),
                .reset (reset),
                .we    (word_we[i]),
                .d     (ld_data),
                .q     (words[i])
            );
        end
    endgenerate

    // State, word count and processor reset register; cpu_reset tracks the
    // state being entered so it is high in every state except RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state   <= IDLE;
            wcount_q    <= 5'd0;
            cpu_reset_q <= 1'b1;
        end else begin
            cur_state   <= next_state;
            wcount_q    <= next_wcount;
            cpu_reset_q <= (next_state != RUN);
        end
    end

    // Next-state and word-count logic; stop has priority over start.
    always_comb begin
        next_state  = cur_state;
        next_wcount = wcount_q;
        case (cur_state)
            IDLE: begin
                if (transfer) begin
                    next_wcount = 5'd1;
                    if (ld_last || (DEPTH_W == 5'd1)) begin
                        next_state = READY;
                    end else begin
                        next_state = LOAD;
                    end
                end
            end
            LOAD: begin
                if (transfer) begin
                    if (wcount_q < DEPTH_W) begin
                        next_wcount = wcount_q + 5'd1;
                    end
                    if (ld_last || (next_wcount == DEPTH_W)) begin
                        next_state = READY;
                    end
                end
            end
            READY: begin
                if (!stop && start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    next_state = READY;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Zero-latency fetch; anything past the loaded program reads as a NOP.
    always_comb begin
        ins = NOP_WORD;
        if ({11'd0, wcount_q} > addr) begin
            ins = words[addr[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: directed stimulus pushes expectations,
// a negedge monitor pops and compares them.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        start;
    logic        stop;
    logic [15:0] addr;
    logic [15:0] ins;
    logic        cpu_reset;
    logic [4:0]  wcount;
    logic [1:0]  state;

    typedef struct packed {
        logic [1:0]  st;
        logic [4:0]  wc;
        logic        rdy;
        logic        cr;
        logic [15:0] ins;
    } expect_t;

    expect_t exp_q[$];
    string   name_q[$];
    logic    probe = 1'b0;
    int      tests_run = 0;
    int      fail_count = 0;

    prog_loader dut (
        .clk       (clk),
        .reset     (reset),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .start     (start),
        .stop      (stop),
        .addr      (addr),
        .ins       (ins),
        .cpu_reset (cpu_reset),
        .wcount    (wcount),
        .state     (state)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_field(input string name, input string field,
                               input logic [15:0] act, input logic [15:0] req);
        tests_run++;
        if (act !== req) begin
            fail_count++;
            $display("[TB] FAIL %s.%s actual=%h expected=%h", name, field, act, req);
        end
    endtask

    // Monitor: pops one expectation per probe and compares every output.
    always @(negedge clk) begin
        if (probe) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                fail_count++;
                $display("[TB] FAIL scoreboard_empty actual=0 expected=1");
            end else begin
                expect_t e;
                string   n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check_field(n, "state",     {14'd0, state},     {14'd0, e.st});
                check_field(n, "wcount",    {11'd0, wcount},    {11'd0, e.wc});
                check_field(n, "ld_ready",  {15'd0, ld_ready},  {15'd0, e.rdy});
                check_field(n, "cpu_reset", {15'd0, cpu_reset}, {15'd0, e.cr});
                check_field(n, "ins",       ins,                e.ins);
            end
        end
    end

    // One clock edge with the given inputs, then inputs return to idle.
    task automatic apply_stimulus(input logic v, input logic [15:0] d,
                                  input logic l, input logic s, input logic p);
        ld_valid = v;
        ld_data  = d;
        ld_last  = l;
        start    = s;
        stop     = p;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_data  = 16'h0000;
        ld_last  = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Pushes an expectation and raises the probe for the next falling edge.
    task automatic check_output(input string name, input logic [15:0] a,
                                input logic [1:0] st, input logic [4:0] wc,
                                input logic rdy, input logic cr,
                                input logic [15:0] exp_ins);
        expect_t e;
        addr  = a;
        e.st  = st;
        e.wc  = wc;
        e.rdy = rdy;
        e.cr  = cr;
        e.ins = exp_ins;
        exp_q.push_back(e);
        name_q.push_back(name);
        probe = 1'b1;
        @(negedge clk);
        #1;
        probe = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; ld_valid = 1'b0; ld_data = 16'h0000; ld_last = 1'b0;
        start = 1'b0; stop = 1'b0; addr = 16'h0000;
        @(negedge clk);
        do_reset();
        check_output("reset", 16'h0000, 2'b00, 5'd0, 1'b1, 1'b1, 16'h0000);

        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check_output("start_in_idle", 16'h0000, 2'b00, 5'd0, 1'b1, 1'b1, 16'h0000);

        apply_stimulus(1'b1, 16'h0A41, 1'b0, 1'b0, 1'b0);
        check_output("load_w0", 16'h0000, 2'b01, 5'd1, 1'b1, 1'b1, 16'h0A41);
        apply_stimulus(1'b1, 16'h0281, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'h0C42, 1'b1, 1'b0, 1'b0);
        check_output("last_addr1", 16'h0001, 2'b10, 5'd3, 1'b0, 1'b1, 16'h0281);
        check_output("last_addr2", 16'h0002, 2'b10, 5'd3, 1'b0, 1'b1, 16'h0C42);
        check_output("last_addr5", 16'h0005, 2'b10, 5'd3, 1'b0, 1'b1, 16'h0000);

        apply_stimulus(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        check_output("valid_in_ready", 16'h0003, 2'b10, 5'd3, 1'b0, 1'b1, 16'h0000);

        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        check_output("stop_start_ready", 16'h0000, 2'b10, 5'd3, 1'b0, 1'b1, 16'h0A41);

        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check_output("run", 16'h0000, 2'b11, 5'd3, 1'b0, 1'b0, 16'h0A41);
        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check_output("run_hold", 16'h0001, 2'b11, 5'd3, 1'b0, 1'b0, 16'h0281);
        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        check_output("stop_start_run", 16'h0002, 2'b10, 5'd3, 1'b0, 1'b1, 16'h0C42);
        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check_output("rerun", 16'h0000, 2'b11, 5'd3, 1'b0, 1'b0, 16'h0A41);
        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check_output("stop_run", 16'h0000, 2'b10, 5'd3, 1'b0, 1'b1, 16'h0A41);
        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        do_reset();
        check_output("reset_in_run", 16'h0000, 2'b00, 5'd0, 1'b1, 1'b1, 16'h0000);

        apply_stimulus(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
        check_output("partial_load", 16'h0001, 2'b01, 5'd2, 1'b1, 1'b1, 16'h2222);
        do_reset();
        check_output("reset_mid_load0", 16'h0000, 2'b00, 5'd0, 1'b1, 1'b1, 16'h0000);
        check_output("reset_mid_load1", 16'h0001, 2'b00, 5'd0, 1'b1, 1'b1, 16'h0000);

        apply_stimulus(1'b1, 16'hABCD, 1'b1, 1'b0, 1'b0);
        check_output("single_last0", 16'h0000, 2'b10, 5'd1, 1'b0, 1'b1, 16'hABCD);
        check_output("single_last1", 16'h0001, 2'b10, 5'd1, 1'b0, 1'b1, 16'h0000);

        do_reset();
        for (int k = 0; k < 16; k++) begin
            apply_stimulus(1'b1, 16'h1000 + 16'(k), 1'b0, 1'b0, 1'b0);
            if (k == 14) begin
                check_output("fill_15", 16'h000E, 2'b01, 5'd15, 1'b1, 1'b1, 16'h100E);
            end
        end
        check_output("fill_16", 16'h000F, 2'b10, 5'd16, 1'b0, 1'b1, 16'h100F);
        apply_stimulus(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
        check_output("fill_17th", 16'h0000, 2'b10, 5'd16, 1'b0, 1'b1, 16'h1000);
        check_output("addr_0010", 16'h0010, 2'b10, 5'd16, 1'b0, 1'b1, 16'h0000);
        check_output("addr_ffff", 16'hFFFF, 2'b10, 5'd16, 1'b0, 1'b1, 16'h0000);
        check_output("addr_0007", 16'h0007, 2'b10, 5'd16, 1'b0, 1'b1, 16'h1007);

        @(negedge clk);
        if (exp_q.size() != 0) begin
            tests_run++;
            fail_count++;
            $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter MEM_DEPTH, default 16, number of 16-bit program words held.
REQ-002 clk  in  1  single system clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 ld_valid  in  1  loader presents a program word on ld_data.
REQ-005 ld_data  in  16  program word to store.
REQ-006 ld_last  in  1  qualifies ld_data as the final word of the program.
REQ-007 ld_ready  out  1  block accepts a word this cycle; a transfer occurs when ld_valid and ld_ready are both 1.
REQ-008 start  in  1  release the processor to execute the loaded program.
REQ-009 stop  in  1  halt the processor and return to the loaded-idle state.
REQ-010 addr  in  16  fetch address from the processor's program counter.
REQ-011 ins  out  16  instruction word returned for addr.
REQ-012 cpu_reset  out  1  reset driven to the processor; 1 holds it in reset.
REQ-013 wcount  out  5  number of words stored since reset (0..MEM_DEPTH).
REQ-014 state  out  2  current FSM state encoding, for observation.

Function
REQ-015 FSM states: IDLE=00, LOAD=01, READY=10, RUN=11.
REQ-016 IDLE: ld_ready=1, cpu_reset=1; on a transfer store the word at index 0, wcount becomes 1, go to LOAD; start and stop ignored.
REQ-017 LOAD: ld_ready=1, cpu_reset=1; each transfer writes mem[wcount] and increments wcount.
REQ-018 LOAD exit: transfer with ld_last=1, or the transfer that makes wcount=MEM_DEPTH, goes to READY on the same edge.
REQ-019 A transfer in IDLE with ld_last=1 goes directly to READY with wcount=1.
REQ-020 READY: ld_ready=0, cpu_reset=1; start=1 goes to RUN; ld_valid ignored.
REQ-021 RUN: ld_ready=0, cpu_reset=0; stop=1 goes to READY (cpu_reset 1 next cycle); memory and wcount unchanged.
REQ-022 stop and start both 1 in READY or RUN: stop wins (stay in/go to READY).
REQ-023 Returning from READY to RUN restarts the processor from address 0 because it saw at least one cycle of cpu_reset=1.
REQ-024 cpu_reset is a registered output, a pure function of the registered state.
REQ-025 ins is combinational from addr: ins = mem[addr[3:0]] when addr < MEM_DEPTH, else 16'h0000; zero-cycle latency so the processor's instruction register captures it in the same fetch cycle.
REQ-026 Locations at or beyond wcount read 16'h0000.
REQ-027 Stored words are immutable outside IDLE/LOAD; reloading requires reset.
REQ-028 wcount saturates at MEM_DEPTH; no wrap to 0.

Reset
REQ-029 reset=1 forces state=IDLE, wcount=0, all memory words=16'h0000, ld_ready=1, cpu_reset=1 at the next edge, regardless of the current state.
REQ-030 reset mid-LOAD discards the partial program; reset in RUN re-asserts cpu_reset.
REQ-031 ins reads 16'h0000 for every addr after reset.

Structure
REQ-032 Shared package holds MEM_DEPTH, the 2-bit state encodings and the NOP word 16'h0000.
REQ-033 One sub-module prog_word: 16-bit register with synchronous reset and write-enable, instantiated MEM_DEPTH times.
REQ-034 Write enable decode, FSM and read mux live in prog_loader; no other sub-modules.

Verification
REQ-035 Reset, then 3 transfers 16'h0A41, 16'h0281, 16'h0C42 with ld_last on the third -> state=READY, wcount=3, ld_ready=0, ins for addr 1 = 16'h0281, addr 5 = 16'h0000.
REQ-036 16 transfers without ld_last -> READY after the 16th edge, wcount=16; 17th ld_valid not accepted (ld_ready=0).
REQ-037 From READY assert start one cycle -> cpu_reset=0 next cycle; stop+start together in RUN -> READY, cpu_reset=1.
REQ-038 Single transfer with ld_last=1 in IDLE -> READY, wcount=1; start in IDLE before loading -> state stays IDLE.
REQ-039 reset asserted after 2 words in LOAD -> IDLE, wcount=0, ins for addr 0 = 16'h0000.
REQ-040 addr=16'h0010 and 16'hFFFF with full memory -> ins=16'h0000.
